muldiv_sequencer: RTL

- Multi-cycle controller and iterative datapath for the HI/LO multiply/divide resource of the MIPS core.
- Replaces the single-cycle HI/LO products and quotients with a 32-iteration shift-add multiplier and restoring divider.
- Owns the HI/LO registers and reports busy so the pipeline stalls MFHI/MFLO and new mul/div issue until results are final.
- Sits beside the ALU in the EX stage. The ALU's MFHI/MFLO paths read oHI/oLO from this block.

---
 rtl/muldiv_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiplier and restoring divider
// with sign pre/post-processing, MTHI/MTLO writes, abort and busy/done handshake.
module muldiv_sequencer #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned ITER = 32,
   parameter int unsigned CNTW = 6
) (
   input  logic            iCLK,
   input  logic            iRST,
   input  logic            iStart,
   input  logic [2:0]      iOp,
   input  logic [XLEN-1:0] iA,
   input  logic [XLEN-1:0] iB,
   input  logic            iAbort,
   output logic            oBusy,
   output logic            oDone,
   output logic [XLEN-1:0] oHI,
   output logic [XLEN-1:0] oLO
);

   localparam int unsigned W2 = 2 * XLEN;
   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;

   typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

   state_t            state;
   logic [CNTW-1:0]   cnt;
   logic [2:0]        opReg;
   logic [XLEN-1:0]   aReg;
   logic [XLEN-1:0]   bReg;
   logic [XLEN-1:0]   opnd;
   logic [W2-1:0]     acc;
   logic              negLo;
   logic              negHi;
   logic              divZero;

   logic              isDiv;
   logic              signA;
   logic              signB;
   logic [XLEN-1:0]   magA;
   logic [XLEN-1:0]   magB;
   logic [XLEN:0]     mulAdd;
   logic [XLEN:0]     mulSum;
   logic [XLEN:0]     divShift;
   logic [XLEN:0]     divDiff;
   logic [W2-1:0]     prodNeg;
   logic [XLEN-1:0]   quoNeg;
   logic [XLEN-1:0]   remNeg;

   // Operand conditioning and one iteration step for each datapath.
   // acc holds the product for multiply, {remainder, dividend/quotient} for divide.
   always_comb begin
      isDiv    = opReg[1];
      signA    = ~opReg[0] & aReg[XLEN-1];
      signB    = ~opReg[0] & bReg[XLEN-1];
      magA     = signA ? (~aReg + XLEN'(1)) : aReg;
      magB     = signB ? (~bReg + XLEN'(1)) : bReg;
      mulAdd   = acc[0] ? {1'b0, opnd} : '0;
      mulSum   = {1'b0, acc[W2-1:XLEN]} + mulAdd;
      divShift = acc[W2-1:XLEN-1];
      divDiff  = divShift - {1'b0, opnd};
      prodNeg  = ~acc + W2'(1);
      quoNeg   = ~acc[XLEN-1:0] + XLEN'(1);
      remNeg   = ~acc[W2-1:XLEN] + XLEN'(1);
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state   <= IDLE;
         cnt     <= '0;
         opReg   <= '0;
         aReg    <= '0;
         bReg    <= '0;
         opnd    <= '0;
         acc     <= '0;
         negLo   <= 1'b0;
         negHi   <= 1'b0;
         divZero <= 1'b0;
         oBusy   <= 1'b0;
         oDone   <= 1'b0;
         oHI     <= '0;
         oLO     <= '0;
      end else begin
         oDone <= 1'b0;
         if (state != IDLE && iAbort) begin
            // Flush wins over every in-flight state, including completion.
            state <= IDLE;
            oBusy <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (iStart && !iAbort) begin
                     case (iOp)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                           aReg  <= iA;
                           bReg  <= iB;
                           opReg <= iOp;
                           state <= PREP;
                           oBusy <= 1'b1;
                        end
                        OP_MTHI: oHI <= iA;
                        OP_MTLO: oLO <= iA;
                        default: ;
                     endcase
                  end
               end
               PREP: begin
                  negLo   <= signA ^ signB;
                  negHi   <= isDiv ? signA : (signA ^ signB);
                  divZero <= isDiv && (bReg == '0);
                  opnd    <= isDiv ? magB : magA;
                  acc     <= {{XLEN{1'b0}}, (isDiv ? magA : magB)};
                  cnt     <= CNTW'(ITER);
                  state   <= RUN;
               end
               RUN: begin
                  if (isDiv) begin
                     if (!divDiff[XLEN])
                        acc <= {divDiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                     else
                        acc <= {divShift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                  end else begin
                     acc <= {mulSum, acc[XLEN-1:1]};
                  end
                  cnt <= cnt - CNTW'(1);
                  if (cnt == CNTW'(1))
                     state <= FIX;
               end
               FIX: begin
                  if (!isDiv) begin
                     {oHI, oLO} <= negLo ? prodNeg : acc;
                  end else if (divZero) begin
                     oLO <= '1;
                     oHI <= aReg;
                  end else begin
                     oLO <= negLo ? quoNeg : acc[XLEN-1:0];
                     oHI <= negHi ? remNeg : acc[W2-1:XLEN];
                  end
                  oDone <= 1'b1;
                  oBusy <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  oBusy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
